cpu4_control_unit: RTL and testbench

CPU4_CONTROL_UNIT -- requirements
Module: cpu4_control_unit

---
 rtl/cpu4_pkg.sv | 50 +++++
 rtl/cpu4_regfile.sv | 42 ++++
 rtl/cpu4_control_unit.sv | 171 +++++++++++++++++
 tb/tb_cpu4_control_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit multi-cycle control unit: FSM states,
// instruction classes, ALU opcodes and instruction field positions.
package cpu4_pkg;

   localparam int DATA_W = 4;
   localparam int PC_W   = 4;
   localparam int IR_W   = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALTED
   } state_t;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'b00,
      CLS_LDI  = 2'b01,
      CLS_JMP  = 2'b10,
      CLS_HALT = 2'b11
   } class_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_INC  = 3'd2;
   localparam logic [2:0] OP_DEC  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_XOR  = 3'd6;
   localparam logic [2:0] OP_XNOR = 3'd7;

   localparam int CLS_HI    = 9;
   localparam int CLS_LO    = 8;
   localparam int OP_HI     = 7;
   localparam int OP_LO     = 5;
   localparam int RD_HI     = 3;
   localparam int RD_LO     = 2;
   localparam int RB_HI     = 1;
   localparam int RB_LO     = 0;
   localparam int LDI_RD_HI = 5;
   localparam int LDI_RD_LO = 4;
   localparam int IMM_HI    = 3;
   localparam int IMM_LO    = 0;
   localparam int JMP_COND  = 7;
   localparam int TGT_HI    = 3;
   localparam int TGT_LO    = 0;

endpackage

// File: rtl/cpu4_regfile.sv
// 4x4 register file: two combinational read ports, one synchronous write
// port, synchronous reset to zero. R0 is exported for observation.
module cpu4_regfile
   import cpu4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        rd_addr_a,
   input  logic [1:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [1:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] r0
);

   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_data_a = regs_q[rd_addr_a];
   assign rd_data_b = regs_q[rd_addr_b];
   assign r0        = regs_q[0];

endmodule

// File: rtl/cpu4_control_unit.sv
// Multi-cycle control unit for a tiny 4-bit CPU: sequences fetch/decode/
// execute/writeback around an external ALU and an internal register file.
module cpu4_control_unit
   import cpu4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [PC_W-1:0]   prog_addr,
   input  logic [IR_W-1:0]   prog_data,
   output logic [2:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_co,
   input  logic              alu_of,
   input  logic              alu_z,
   output logic              flag_co,
   output logic              flag_of,
   output logic              flag_z,
   output logic              busy,
   output logic              halted,
   output logic [DATA_W-1:0] r0
);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [2:0]        alu_opcode_q, alu_opcode_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              flag_co_q, flag_co_d;
   logic              flag_of_q, flag_of_d;
   logic              flag_z_q, flag_z_d;

   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic              wr_en;
   logic [1:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;

   class_t ir_class;
   assign ir_class = class_t'(ir_q[CLS_HI:CLS_LO]);

   cpu4_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (ir_q[RD_HI:RD_LO]),
      .rd_addr_b (ir_q[RB_HI:RB_LO]),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .r0        (r0)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         ir_q         <= '0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         result_q     <= '0;
         flag_co_q    <= 1'b0;
         flag_of_q    <= 1'b0;
         flag_z_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         result_q     <= result_d;
         flag_co_q    <= flag_co_d;
         flag_of_q    <= flag_of_d;
         flag_z_q     <= flag_z_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      result_d     = result_q;
      flag_co_d    = flag_co_q;
      flag_of_d    = flag_of_q;
      flag_z_d     = flag_z_q;
      wr_en        = 1'b0;
      wr_addr      = ir_q[RD_HI:RD_LO];
      wr_data      = result_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            ir_d    = prog_data;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (ir_class)
               CLS_ALU: begin
                  alu_opcode_d = ir_q[OP_HI:OP_LO];
                  alu_a_d      = rd_data_a;
                  alu_b_d      = rd_data_b;
                  state_d      = ST_EXEC;
               end
               CLS_LDI: begin
                  wr_en   = 1'b1;
                  wr_addr = ir_q[LDI_RD_HI:LDI_RD_LO];
                  wr_data = ir_q[IMM_HI:IMM_LO];
                  pc_d    = pc_q + 4'd1;
                  state_d = ST_FETCH;
               end
               CLS_JMP: begin
                  // Conditional jumps see the flag value registered before this cycle
                  if (!ir_q[JMP_COND] || flag_z_q) begin
                     pc_d = ir_q[TGT_HI:TGT_LO];
                  end else begin
                     pc_d = pc_q + 4'd1;
                  end
                  state_d = ST_FETCH;
               end
               default: begin
                  state_d = ST_HALTED;
               end
            endcase
         end
         ST_EXEC: begin
            result_d  = alu_result;
            flag_co_d = alu_co;
            flag_of_d = alu_of;
            flag_z_d  = alu_z;
            state_d   = ST_WB;
         end
         ST_WB: begin
            wr_en   = 1'b1;
            pc_d    = pc_q + 4'd1;
            state_d = ST_FETCH;
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign prog_addr  = pc_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign flag_co    = flag_co_q;
   assign flag_of    = flag_of_q;
   assign flag_z     = flag_z_q;
   // Status is masked while reset is asserted, before the reset edge lands
   assign busy       = !rst && (state_q != ST_IDLE) && (state_q != ST_HALTED);
   assign halted     = !rst && (state_q == ST_HALTED);

endmodule

// File: tb/tb_cpu4_control_unit.sv
// Self-checking bench: ROM and ALU modelled in the bench, DUT checked per
// instruction against an instruction-level reference model.
module tb_cpu4_control_unit;
   import cpu4_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] prog_addr;
   logic [9:0] prog_data;
   logic [2:0] alu_opcode;
   logic [3:0] alu_a, alu_b, alu_result;
   logic       alu_co, alu_of, alu_z;
   logic       flag_co, flag_of, flag_z;
   logic       busy, halted;
   logic [3:0] r0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [9:0] rom [16];

   int         m_pc;
   logic [3:0] m_r [4];
   logic       m_co, m_of, m_z, m_halted;

   cpu4_control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_co     (alu_co),
      .alu_of     (alu_of),
      .alu_z      (alu_z),
      .flag_co    (flag_co),
      .flag_of    (flag_of),
      .flag_z     (flag_z),
      .busy       (busy),
      .halted     (halted),
      .r0         (r0)
   );

   always #5 clk = ~clk;

   // Returns {co, of, z, result[3:0]} computed with plain integer arithmetic
   function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int ua, ub, sa, sb, u, s;
      logic co, of;
      logic [3:0] res;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      u = 0; s = 0; co = 1'b0; of = 1'b0;
      case (op)
         OP_ADD:  begin u = ua + ub; s = sa + sb; co = (u > 15); of = (s > 7) || (s < -8); end
         OP_SUB:  begin u = ua - ub; s = sa - sb; co = (u < 0);  of = (s > 7) || (s < -8); end
         OP_INC:  begin u = ua + 1;  s = sa + 1;  co = (u > 15); of = (s > 7); end
         OP_DEC:  begin u = ua - 1;  s = sa - 1;  co = (u < 0);  of = (s < -8); end
         OP_AND:  u = ua & ub;
         OP_OR:   u = ua | ub;
         OP_XOR:  u = ua ^ ub;
         default: u = ~(ua ^ ub);
      endcase
      res = 4'(u & 15);
      return {co, of, (res == 4'd0), res};
   endfunction

   assign prog_data = rom[prog_addr];
   always_comb {alu_co, alu_of, alu_z, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

   function automatic logic [9:0] enc_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rb);
      return {2'b00, op, 1'b0, rd, rb};
   endfunction
   function automatic logic [9:0] enc_ldi(input logic [1:0] rd, input logic [3:0] imm);
      return {2'b01, 2'b00, rd, imm};
   endfunction
   function automatic logic [9:0] enc_jmp(input logic cond, input logic [3:0] tgt);
      return {2'b10, cond, 3'b000, tgt};
   endfunction
   localparam logic [9:0] ENC_HALT = 10'b11_0000_0000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = ENC_HALT;
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
      m_co = 1'b0; m_of = 1'b0; m_z = 1'b0; m_halted = 1'b0;
   endtask

   task automatic model_step();
      logic [9:0] ins;
      logic [6:0] res;
      ins = rom[m_pc];
      case (ins[9:8])
         2'b00: begin
            res = alu_fn(ins[7:5], m_r[ins[3:2]], m_r[ins[1:0]]);
            m_r[ins[3:2]] = res[3:0];
            m_co = res[6]; m_of = res[5]; m_z = res[4];
            m_pc = (m_pc + 1) % 16;
         end
         2'b01: begin
            m_r[ins[5:4]] = ins[3:0];
            m_pc = (m_pc + 1) % 16;
         end
         2'b10: begin
            if (!ins[7] || m_z) m_pc = int'(ins[3:0]);
            else m_pc = (m_pc + 1) % 16;
         end
         default: m_halted = 1'b1;
      endcase
   endtask

   task automatic start_prog();
      rst = 1'b1; start = 1'b0;
      tick();
      rst = 1'b0;
      model_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Steps the DUT instruction by instruction using the per-class cycle counts
   task automatic exec_and_check(input int max_instr, input string tag);
      logic [9:0] ins;
      for (int i = 0; i < max_instr; i++) begin
         if (m_halted) break;
         ins = rom[m_pc];
         n_checks++;
         if (prog_addr !== 4'(m_pc) || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s fetch[%0d]: prog_addr=%0d busy=%b, expected prog_addr=%0d busy=1",
                     tag, i, prog_addr, busy, m_pc);
         end
         tick(); tick();
         if (ins[9:8] == 2'b00) begin
            n_checks++;
            if ({alu_opcode, alu_a, alu_b} !== {ins[7:5], m_r[ins[3:2]], m_r[ins[1:0]]}) begin
               n_fail++;
               $display("[TB] FAIL %s operands[%0d]: op=%0d a=%0d b=%0d, expected op=%0d a=%0d b=%0d",
                        tag, i, alu_opcode, alu_a, alu_b, ins[7:5], m_r[ins[3:2]], m_r[ins[1:0]]);
            end
            tick(); tick();
         end
         model_step();
         n_checks++;
         if (r0 !== m_r[0] || {flag_co, flag_of, flag_z} !== {m_co, m_of, m_z} ||
             halted !== m_halted || busy !== !m_halted || prog_addr !== 4'(m_pc)) begin
            n_fail++;
            $display("[TB] FAIL %s retire[%0d]: r0=%0d cvz=%b%b%b halted=%b busy=%b pc=%0d, expected r0=%0d cvz=%b%b%b halted=%b busy=%b pc=%0d",
                     tag, i, r0, flag_co, flag_of, flag_z, halted, busy, prog_addr,
                     m_r[0], m_co, m_of, m_z, m_halted, !m_halted, m_pc);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      tick();
      n_checks++;
      if ({busy, halted, prog_addr, r0, flag_co, flag_of, flag_z, alu_opcode, alu_a, alu_b} !== 24'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: busy=%b halted=%b pc=%0d r0=%0d cvz=%b%b%b op=%0d a=%0d b=%0d, expected all 0",
                  busy, halted, prog_addr, r0, flag_co, flag_of, flag_z, alu_opcode, alu_a, alu_b);
      end
      rst = 1'b0; start = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || prog_addr !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL idle_hold: busy=%b pc=%0d, expected busy=0 pc=0", busy, prog_addr);
      end
   endtask

   task automatic test_basic_program();
      clear_rom();
      rom[0] = enc_ldi(2'd1, 4'd5);
      rom[1] = enc_ldi(2'd2, 4'd3);
      rom[2] = enc_alu(OP_ADD, 2'd1, 2'd2);
      rom[3] = ENC_HALT;
      start_prog();
      exec_and_check(4, "basic");
      n_checks++;
      if (halted !== 1'b1 || flag_z !== 1'b0 || flag_co !== 1'b0 || m_r[1] !== 4'd8) begin
         n_fail++;
         $display("[TB] FAIL basic_final: halted=%b z=%b co=%b, expected halted=1 z=0 co=0", halted, flag_z, flag_co);
      end
   endtask

   task automatic test_flags_jump();
      clear_rom();
      rom[0] = enc_ldi(2'd0, 4'd15);
      rom[1] = enc_alu(OP_INC, 2'd0, 2'd0);
      rom[2] = enc_jmp(1'b1, 4'd9);
      start_prog();
      exec_and_check(3, "jump_taken");
      n_checks++;
      if (r0 !== 4'd0 || flag_co !== 1'b1 || flag_z !== 1'b1 || prog_addr !== 4'd9) begin
         n_fail++;
         $display("[TB] FAIL jump_taken_final: r0=%0d co=%b z=%b pc=%0d, expected r0=0 co=1 z=1 pc=9",
                  r0, flag_co, flag_z, prog_addr);
      end
      exec_and_check(1, "jump_taken_halt");
   endtask

   task automatic test_no_jump();
      clear_rom();
      rom[0] = enc_ldi(2'd3, 4'd7);
      rom[1] = enc_alu(OP_INC, 2'd3, 2'd3);
      rom[2] = enc_jmp(1'b1, 4'd9);
      start_prog();
      exec_and_check(3, "jump_not_taken");
      n_checks++;
      if (flag_of !== 1'b1 || flag_z !== 1'b0 || prog_addr !== 4'd3) begin
         n_fail++;
         $display("[TB] FAIL jump_not_taken_final: of=%b z=%b pc=%0d, expected of=1 z=0 pc=3",
                  flag_of, flag_z, prog_addr);
      end
      exec_and_check(1, "jump_not_taken_halt");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) rom[i] = enc_ldi(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      start_prog();
      exec_and_check(20, "wrap");
      n_checks++;
      if (busy !== 1'b1 || prog_addr !== 4'd4 || halted !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL wrap_final: busy=%b pc=%0d halted=%b, expected busy=1 pc=4 halted=0",
                  busy, prog_addr, halted);
      end
   endtask

   task automatic test_reset_mid_instr();
      clear_rom();
      rom[0] = enc_ldi(2'd0, 4'd9);
      rom[1] = enc_ldi(2'd1, 4'd2);
      rom[2] = enc_alu(OP_SUB, 2'd0, 2'd1);
      start_prog();
      exec_and_check(2, "mid_reset_pre");
      tick(); tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || halted !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_status_mask: busy=%b halted=%b, expected 0 0", busy, halted);
      end
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if ({busy, prog_addr, r0, flag_co, flag_of, flag_z, alu_opcode, alu_a, alu_b} !== 23'd0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_state: busy=%b pc=%0d r0=%0d cvz=%b%b%b op=%0d a=%0d b=%0d, expected all 0",
                  busy, prog_addr, r0, flag_co, flag_of, flag_z, alu_opcode, alu_a, alu_b);
      end
      model_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      exec_and_check(4, "mid_reset_restart");
      n_checks++;
      if (r0 !== 4'd7 || halted !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_restart_final: r0=%0d halted=%b, expected r0=7 halted=1", r0, halted);
      end
   endtask

   task automatic test_start_ignored();
      clear_rom();
      rom[0] = enc_ldi(2'd2, 4'd1);
      rom[1] = enc_alu(OP_DEC, 2'd2, 2'd2);
      rom[2] = enc_jmp(1'b0, 4'd6);
      rom[6] = enc_ldi(2'd0, 4'd12);
      start_prog();
      start = 1'b1;
      exec_and_check(10, "start_held");
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (halted !== 1'b1 || busy !== 1'b0 || prog_addr !== 4'd7 || r0 !== 4'd12) begin
            n_fail++;
            $display("[TB] FAIL halted_hold[%0d]: halted=%b busy=%b pc=%0d r0=%0d, expected 1 0 7 12",
                     i, halted, busy, prog_addr, r0);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_random_programs();
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 16; i++) rom[i] = 10'($urandom_range(0, 1023));
         start_prog();
         exec_and_check(40, $sformatf("random%0d", p));
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      clear_rom();
      model_reset();
      test_reset();
      test_basic_program();
      test_flags_jump();
      test_no_jump();
      test_wrap();
      test_reset_mid_instr();
      test_start_ignored();
      test_random_programs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
